// File: rtl/qtree_lookup_ingress.sv
// Credit-gated ingress for the qtree lookup pipeline: admits keys, tags them with a sequence
// number and launches them into the first level one cycle later.
module qtree_lookup_ingress #(
  parameter int unsigned KEY_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned BYPASS_WIDTH = 8,
  parameter int unsigned CREDITS      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [KEY_WIDTH-1:0]            req_key_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            credit_return_i,
  output logic [KEY_WIDTH+ADDR_WIDTH-1:0] out_data_o,
  output logic [BYPASS_WIDTH-1:0]         out_bypass_o,
  output logic                            out_valid_o,
  output logic [7:0]                      credits_o,
  output logic                            idle_o,
  output logic                            err_o
);

  localparam int unsigned DataWidth   = KEY_WIDTH + ADDR_WIDTH;
  localparam logic [7:0]  CreditsFull = 8'(CREDITS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              credits_q, credits_d;
  logic [BYPASS_WIDTH-1:0] tag_q, tag_d;
  logic                    err_q, err_d;
  logic                    out_valid_q, out_valid_d;
  logic [DataWidth-1:0]    out_data_q, out_data_d;
  logic [BYPASS_WIDTH-1:0] out_bypass_q, out_bypass_d;
  logic                    accept;

  // Ready depends only on registered state, never on req_valid_i.
  assign req_ready_o = (state_q == StRun) && (credits_q != 8'd0);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    credits_d    = credits_q;
    err_d        = err_q;
    tag_d        = tag_q;
    out_valid_d  = accept;
    out_data_d   = out_data_q;
    out_bypass_d = out_bypass_q;

    if (accept) begin
      out_data_d   = {req_key_i, {ADDR_WIDTH{1'b0}}};
      out_bypass_d = tag_q;
      tag_d        = tag_q + BYPASS_WIDTH'(1);
    end

    if (accept && !credit_return_i) begin
      credits_d = credits_q - 8'd1;
    end else if (credit_return_i && !accept) begin
      if (credits_q == CreditsFull) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_i) state_d = StRun;
      StRun:   if (!en_i) state_d = StDrain;
      // Leave as soon as the last credit lands, using the updated count.
      StDrain: begin
        if (en_i) begin
          state_d = StRun;
        end else if (credits_d == CreditsFull) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      credits_q    <= CreditsFull;
      tag_q        <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_bypass_q <= '0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_bypass_q <= out_bypass_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign out_bypass_o = out_bypass_q;
  assign credits_o    = credits_q;
  assign idle_o       = (state_q == StIdle);
  assign err_o        = err_q;

endmodule
